// File: rtl/mem_lsu.sv
// mem_lsu: sequential load/store unit. Takes one load or store per request
// handshake, splits it into bus-word beats on a wait-stateable req/ack RAM
// port, and returns the extended write-back value with a one-cycle pulse.
//
// Handshakes:
//   Request side: a request is taken on a rising edge where
//   req_valid_i && req_ready_o. req_ready_o is high only in IDLE, so
//   req_valid_i is ignored while an access is in flight.
//   Bus side: while mem_req_o is high, mem_addr_o/mem_sel_o/mem_wdata_o/
//   mem_we_o stay stable until a rising edge samples mem_ack_i high. That
//   edge completes the beat, and the next beat's fields appear in the
//   following cycle with mem_req_o still high. mem_ack_i is ignored
//   outside ACCESS.
module mem_lsu #(
  parameter int BUS_BYTES   = 4,
  parameter int BIG_ENDIAN  = 1,
  parameter int MISALIGN_OK = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   store_i,
  input  logic [2:0]             func3_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [4:0]             wd_i,
  output logic                   resp_valid_o,
  output logic                   err_o,
  output logic [4:0]             wd_o,
  output logic                   wreg_o,
  output logic [31:0]            wdata_o,
  output logic                   stall_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [BUS_BYTES-1:0]   mem_sel_o,
  output logic [8*BUS_BYTES-1:0] mem_wdata_o,
  input  logic                   mem_ack_i,
  input  logic [8*BUS_BYTES-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] OFF_MASK = 32'(BUS_BYTES - 1);
  localparam logic [2:0]  BB3      = 3'(BUS_BYTES);

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wd_q, wd_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  done_q, done_d;
  logic [31:0] asm_q, asm_d;
  logic        resp_valid_q, resp_valid_d;
  logic        err_q, err_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  wd_out_q, wd_out_d;
  logic [31:0] result_q, result_d;

  // Request decode
  logic [2:0] req_size;
  logic       req_illegal;
  logic       req_misaligned;
  logic       req_err;

  // Current beat geometry
  logic [31:0]            beat_addr;
  logic [31:0]            beat_word;
  logic [2:0]             beat_off;
  logic [2:0]             beat_room;
  logic [2:0]             beat_left;
  logic [2:0]             beat_cnt;
  logic                   last_beat;
  logic [2:0]             lane_off;
  logic [2:0]             byte_idx;
  logic [1:0]             val_pos;
  logic [BUS_BYTES-1:0]   lane_sel;
  logic [1:0]             lane_pos [BUS_BYTES];
  logic [8*BUS_BYTES-1:0] lane_wdata;
  logic                   in_access;

  // Sign or zero extension of the assembled load value by access size
  function automatic logic [31:0] extend(input logic [31:0] v,
                                         input logic [2:0]  sz,
                                         input logic        uns);
    case (sz)
      3'd1:    return uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      3'd2:    return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Size, legality and alignment of the incoming request
  always_comb begin
    case (func3_i[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    // Loads allow 000/001/010/100/101, stores only 000/001/010
    req_illegal    = (func3_i[1:0] == 2'b11) ||
                     (store_i && func3_i[2]) ||
                     (!store_i && func3_i[2] && func3_i[1]);
    req_misaligned = (addr_i[1:0] & (req_size[1:0] - 2'd1)) != 2'd0;
    req_err        = req_illegal || ((MISALIGN_OK == 0) && req_misaligned);
  end

  // Beat k covers the remaining bytes that fall in the current bus word;
  // map each lane to its byte position within the value
  always_comb begin
    beat_addr  = addr_q + 32'(done_q);
    beat_word  = beat_addr & ~OFF_MASK;
    beat_off   = 3'(beat_addr & OFF_MASK);
    beat_room  = BB3 - beat_off;
    beat_left  = size_q - done_q;
    beat_cnt   = (beat_left < beat_room) ? beat_left : beat_room;
    last_beat  = (done_q + beat_cnt) == size_q;
    lane_off   = '0;
    byte_idx   = '0;
    val_pos    = '0;
    lane_sel   = '0;
    lane_wdata = '0;
    lane_pos   = '{default: 2'b00};
    for (int l = 0; l < BUS_BYTES; l++) begin
      lane_off = (BIG_ENDIAN != 0) ? 3'(BUS_BYTES - 1 - l) : 3'(l);
      if ((lane_off >= beat_off) && (lane_off < (beat_off + beat_cnt))) begin
        byte_idx      = done_q + lane_off - beat_off;
        val_pos       = (BIG_ENDIAN != 0) ? 2'(size_q - 3'd1 - byte_idx) : byte_idx[1:0];
        lane_sel[l]   = 1'b1;
        lane_pos[l]   = val_pos;
        lane_wdata[8*l +: 8] = wdata_q[{val_pos, 3'b000} +: 8];
      end
    end
  end

  // Next-state and capture logic for the access FSM
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wd_d         = wd_q;
    size_d       = size_q;
    done_d       = done_q;
    asm_d        = asm_q;
    wd_out_d     = wd_out_q;
    result_d     = result_q;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    wreg_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          store_d = store_i;
          uns_d   = func3_i[2];
          addr_d  = addr_i;
          wdata_d = wdata_i;
          wd_d    = wd_i;
          size_d  = req_size;
          done_d  = 3'd0;
          asm_d   = 32'h0;
          if (req_err) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            wd_out_d     = wd_i;
            result_d     = 32'h0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack_i) begin
          if (!store_q) begin
            for (int l = 0; l < BUS_BYTES; l++) begin
              if (lane_sel[l]) asm_d[{lane_pos[l], 3'b000} +: 8] = mem_rdata_i[8*l +: 8];
            end
          end
          done_d = done_q + beat_cnt;
          if (last_beat) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            wreg_d       = !store_q;
            wd_out_d     = wd_q;
            result_d     = store_q ? 32'h0 : extend(asm_d, size_q, uns_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; async reset abandons any beat in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wd_q         <= 5'h0;
      size_q       <= 3'd0;
      done_q       <= 3'd0;
      asm_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      wreg_q       <= 1'b0;
      wd_out_q     <= 5'h0;
      result_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wd_q         <= wd_d;
      size_q       <= size_d;
      done_q       <= done_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      wreg_q       <= wreg_d;
      wd_out_q     <= wd_out_d;
      result_q     <= result_d;
    end
  end

  assign in_access    = (state_q == ST_ACCESS);
  assign req_ready_o  = (state_q == ST_IDLE);
  assign stall_o      = (state_q != ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign err_o        = err_q;
  assign wreg_o       = wreg_q;
  assign wd_o         = wd_out_q;
  assign wdata_o      = result_q;
  assign mem_req_o    = in_access;
  assign mem_we_o     = in_access && store_q;
  assign mem_addr_o   = in_access ? beat_word : 32'h0;
  assign mem_sel_o    = in_access ? lane_sel : '0;
  assign mem_wdata_o  = (in_access && store_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu. Four instances cover the
// parameter corners: 0 = 4-byte big-endian, 1 = 1-byte big-endian,
// 2 = 4-byte little-endian, 3 = 4-byte big-endian with misalignment errors.
module tb_mem_lsu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // ---------------- DUT signals (index = instance) ----------------
  logic [3:0]       rv = '0, st = '0, ack = '0;
  logic [3:0][2:0]  f3 = '0;
  logic [3:0][31:0] ad = '0, wdi32 = '0, rd = '0;
  logic [3:0][4:0]  wdi = '0;
  logic [3:0]       rdy, rvo, err, wreg, stall, mreq, mwe;
  logic [3:0][4:0]  wdo;
  logic [3:0][31:0] wdo32, maddr, mwd;
  logic [3:0][3:0]  msel;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int BB = (g == 1) ? 1 : 4;
    mem_lsu #(
      .BUS_BYTES  (BB),
      .BIG_ENDIAN ((g == 2) ? 0 : 1),
      .MISALIGN_OK((g == 3) ? 0 : 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (rv[g]),
      .req_ready_o (rdy[g]),
      .store_i     (st[g]),
      .func3_i     (f3[g]),
      .addr_i      (ad[g]),
      .wdata_i     (wdi32[g]),
      .wd_i        (wdi[g]),
      .resp_valid_o(rvo[g]),
      .err_o       (err[g]),
      .wd_o        (wdo[g]),
      .wreg_o      (wreg[g]),
      .wdata_o     (wdo32[g]),
      .stall_o     (stall[g]),
      .mem_req_o   (mreq[g]),
      .mem_we_o    (mwe[g]),
      .mem_addr_o  (maddr[g]),
      .mem_sel_o   (msel[g][BB-1:0]),
      .mem_wdata_o (mwd[g][8*BB-1:0]),
      .mem_ack_i   (ack[g]),
      .mem_rdata_i (rd[g][8*BB-1:0])
    );
    if (BB < 4) begin : g_pad
      assign msel[g][3:BB]    = '0;
      assign mwd[g][31:8*BB]  = '0;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- bus responder / response monitor ----------------
  int          wait_n[4]   = '{0, 0, 0, 0};
  int          wcnt[4]     = '{0, 0, 0, 0};
  int          nbeat[4]    = '{0, 0, 0, 0};
  int          mreq_cnt[4] = '{0, 0, 0, 0};
  int          acc_e[4]    = '{0, 0, 0, 0};
  int          r_cyc[4]    = '{0, 0, 0, 0};
  logic        got[4], r_err[4], r_wreg[4], r_stall[4];
  logic [4:0]  r_wd[4];
  logic [31:0] beat_rd[4][8];
  logic [31:0] b_addr[4][8], b_wd[4][8];
  logic [3:0]  b_sel[4][8];
  logic        b_we[4][8];
  logic [31:0] first_addr[4];
  logic [3:0]  first_sel[4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mreq[i]) begin
        mreq_cnt[i]++;
        if (wcnt[i] == 0) begin
          first_addr[i] = maddr[i];
          first_sel[i]  = msel[i];
        end
        if (wcnt[i] >= wait_n[i]) begin
          if (wait_n[i] > 0) begin
            check("beat_addr_stable", maddr[i], first_addr[i]);
            check("beat_sel_stable", {28'h0, msel[i]}, {28'h0, first_sel[i]});
          end
          ack[i]           = 1'b1;
          rd[i]            = beat_rd[i][nbeat[i]];
          b_addr[i][nbeat[i]] = maddr[i];
          b_sel[i][nbeat[i]]  = msel[i];
          b_wd[i][nbeat[i]]   = mwd[i];
          b_we[i][nbeat[i]]   = mwe[i];
          if (nbeat[i] < 7) nbeat[i]++;
          wcnt[i] = 0;
        end else begin
          ack[i] = 1'b0;
          wcnt[i]++;
        end
      end else begin
        ack[i]  = 1'b0;
        wcnt[i] = 0;
      end
      if (rvo[i]) begin
        r_cyc[i]   = ecnt - acc_e[i];
        r_err[i]   = err[i];
        r_wreg[i]  = wreg[i];
        r_wd[i]    = wdo[i];
        r_stall[i] = stall[i];
        got[i]     = 1'b1;
        if (exp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else check("resp_wdata", wdo32[i], exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] w, input int wt);
    int n = 0;
    @(negedge clk);
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    nbeat[i]    = 0;
    got[i]      = 1'b0;
    wait_n[i]   = wt;
    mreq_cnt[i] = 0;
    st[i]    = s;
    f3[i]    = f;
    ad[i]    = a;
    wdi32[i] = d;
    wdi[i]   = w;
    rv[i]    = 1'b1;
    acc_e[i] = ecnt;
    @(negedge clk);
    rv[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i);
    int n = 0;
    while (!got[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", {31'h0, got[i]}, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  logic [7:0] t2_b[4];
  int acc_cnt, stall_cnt, first_acc, second_acc, n;
  logic drop;

  initial begin
    t2_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      got[i] = 1'b0;
      for (int k = 0; k < 8; k++) beat_rd[i][k] = 32'h0;
    end

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, rdy[0]}, 32'd1);
    check("rst_resp", {31'h0, rvo[0]}, 32'd0);
    check("rst_req", {31'h0, mreq[0]}, 32'd0);
    check("rst_stall", {31'h0, stall[1]}, 32'd0);
    check("rst_wdata", wdo32[0], 32'h0);
    check("rst_sel", {28'h0, msel[0]}, 32'h0);
    rst = 1'b1;

    // LB big-endian, byte at offset 3 lives in lane 0
    beat_rd[0][0] = 32'h112233F0;
    exp_q.push_back(32'hFFFFFFF0);
    issue(0, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 0);
    wait_resp(0);
    check("lb_cycle", r_cyc[0], 32'd2);
    check("lb_addr", b_addr[0][0], 32'h100);
    check("lb_sel", {28'h0, b_sel[0][0]}, 32'h1);
    check("lb_wreg", {31'h0, r_wreg[0]}, 32'd1);
    check("lb_err", {31'h0, r_err[0]}, 32'd0);
    check("lb_wd", {27'h0, r_wd[0]}, 32'd5);
    check("lb_stall", {31'h0, r_stall[0]}, 32'd1);
    check("lb_beats", nbeat[0], 32'd1);

    // SW on a byte-wide bus: four beats, MSB first
    exp_q.push_back(32'h0);
    issue(1, 1'b1, 3'b010, 32'h200, 32'hA1B2C3D4, 5'd7, 0);
    wait_resp(1);
    check("sw8_cycle", r_cyc[1], 32'd5);
    check("sw8_wreg", {31'h0, r_wreg[1]}, 32'd0);
    check("sw8_beats", nbeat[1], 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("sw8_addr", b_addr[1][k], 32'h200 + 32'(k));
      check("sw8_data", b_wd[1][k], {24'h0, t2_b[k]});
      check("sw8_sel", {28'h0, b_sel[1][k]}, 32'h1);
      check("sw8_we", {31'h0, b_we[1][k]}, 32'd1);
    end

    // LHU little-endian straddling a word, two wait cycles per beat
    beat_rd[2][0] = 32'h80000000;
    beat_rd[2][1] = 32'h0000007F;
    exp_q.push_back(32'h00007F80);
    issue(2, 1'b0, 3'b101, 32'h3, 32'h0, 5'd9, 2);
    wait_resp(2);
    check("lhu_cycle", r_cyc[2], 32'd7);
    check("lhu_addr0", b_addr[2][0], 32'h0);
    check("lhu_sel0", {28'h0, b_sel[2][0]}, 32'h8);
    check("lhu_addr1", b_addr[2][1], 32'h4);
    check("lhu_sel1", {28'h0, b_sel[2][1]}, 32'h1);
    check("lhu_wreg", {31'h0, r_wreg[2]}, 32'd1);

    // errors without bus traffic: misaligned LW, load func3 011, store func3 100
    exp_q.push_back(32'h0);
    issue(3, 1'b0, 3'b010, 32'h6, 32'h0, 5'd3, 0);
    wait_resp(3);
    check("mis_cycle", r_cyc[3], 32'd1);
    check("mis_err", {31'h0, r_err[3]}, 32'd1);
    check("mis_wreg", {31'h0, r_wreg[3]}, 32'd0);
    check("mis_noreq", mreq_cnt[3], 32'd0);
    exp_q.push_back(32'h0);
    issue(3, 1'b0, 3'b011, 32'h0, 32'h0, 5'd4, 0);
    wait_resp(3);
    check("f3_cycle", r_cyc[3], 32'd1);
    check("f3_err", {31'h0, r_err[3]}, 32'd1);
    check("f3_noreq", mreq_cnt[3], 32'd0);
    exp_q.push_back(32'h0);
    issue(3, 1'b1, 3'b100, 32'h0, 32'h12345678, 5'd4, 0);
    wait_resp(3);
    check("sf3_err", {31'h0, r_err[3]}, 32'd1);
    check("sf3_noreq", mreq_cnt[3], 32'd0);

    // aligned LW on the strict instance is fine
    beat_rd[3][0] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    issue(3, 1'b0, 3'b010, 32'h8, 32'h0, 5'd6, 0);
    wait_resp(3);
    check("lw_err", {31'h0, r_err[3]}, 32'd0);
    check("lw_cycle", r_cyc[3], 32'd2);
    check("lw_sel", {28'h0, b_sel[3][0]}, 32'hF);
    check("lw_addr", b_addr[3][0], 32'h8);

    // SW big-endian straddling 0x100/0x104
    exp_q.push_back(32'h0);
    issue(0, 1'b1, 3'b010, 32'h102, 32'h11223344, 5'd1, 0);
    wait_resp(0);
    check("sws_cycle", r_cyc[0], 32'd3);
    check("sws_addr0", b_addr[0][0], 32'h100);
    check("sws_sel0", {28'h0, b_sel[0][0]}, 32'h3);
    check("sws_data0", b_wd[0][0], 32'h00001122);
    check("sws_addr1", b_addr[0][1], 32'h104);
    check("sws_sel1", {28'h0, b_sel[0][1]}, 32'hC);
    check("sws_data1", b_wd[0][1], 32'h33440000);

    // LH big-endian sign extension
    beat_rd[0][0] = 32'h00008001;
    exp_q.push_back(32'hFFFF8001);
    issue(0, 1'b0, 3'b001, 32'h106, 32'h0, 5'd2, 0);
    wait_resp(0);
    check("lh_cycle", r_cyc[0], 32'd2);
    check("lh_sel", {28'h0, b_sel[0][0]}, 32'h3);

    // async reset in the middle of a wait-stated beat
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 5'd8, 5);
    repeat (2) @(negedge clk);
    check("rstmid_req_up", {31'h0, mreq[0]}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_req", {31'h0, mreq[0]}, 32'd0);
    check("rstmid_ready", {31'h0, rdy[0]}, 32'd1);
    check("rstmid_stall", {31'h0, stall[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    beat_rd[0][0] = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    issue(0, 1'b0, 3'b010, 32'h20, 32'h0, 5'd12, 1);
    wait_resp(0);
    check("post_rst_cycle", r_cyc[0], 32'd3);
    check("post_rst_addr", b_addr[0][0], 32'h20);
    check("post_rst_sel", {28'h0, b_sel[0][0]}, 32'hF);

    // back-to-back LBU with req_valid_i held high
    @(negedge clk);
    nbeat[0]      = 0;
    wait_n[0]     = 0;
    beat_rd[0][0] = 32'h00AA0000;
    beat_rd[0][1] = 32'h00550000;
    exp_q.push_back(32'h000000AA);
    exp_q.push_back(32'h00000055);
    st[0] = 1'b0; f3[0] = 3'b100; ad[0] = 32'h101; wdi[0] = 5'd3;
    rv[0] = 1'b1;
    acc_cnt = 0; stall_cnt = 0; first_acc = -1; second_acc = -1; drop = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (drop) rv[0] = 1'b0;
      if (rv[0] && rdy[0]) begin
        if (acc_cnt == 0) first_acc = c;
        else second_acc = c;
        acc_cnt++;
        if (acc_cnt == 2) drop = 1'b1;
      end
      if (stall[0]) stall_cnt++;
      @(negedge clk);
    end
    check("b2b_accepts", acc_cnt, 32'd2);
    check("b2b_gap", second_acc - first_acc, 32'd3);
    check("b2b_stall", stall_cnt, 32'd4);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Sequential, parametrised load/store unit that replaces the single-cycle combinational memory stage.
- Accepts one load or store per request handshake from the execute/memory pipeline register.
- Splits each access into one or more bus beats of BUS_BYTES bytes on a req/ack RAM port that may wait-state.
- Returns the sign/zero-extended write-back result with a single-cycle response pulse; holds the pipeline via stall_o.

Parameters:
- BUS_BYTES, 4, bytes per bus beat; legal values 1, 2, 4.
- BIG_ENDIAN, 1, 1: byte at lowest address is the MSB of the value and sits in the highest lane. 0: little-endian.
- MISALIGN_OK, 1, 1: misaligned LH/LHU/LW/SH/SW are split into beats. 0: flagged as error, no bus traffic.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- store_i  in  1  1 = store, 0 = load.
- func3_i  in  3  load: LB=000 LH=001 LW=010 LBU=100 LHU=101; store: SB=000 SH=001 SW=010.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data (rs2).
- wd_i  in  5  destination register.
- resp_valid_o  out  1  one-cycle completion pulse.
- err_o  out  1  with resp_valid_o: misaligned or illegal func3.
- wd_o  out  5  destination register.
- wreg_o  out  1  write-back enable.
- wdata_o  out  32  extended load result.
- stall_o  out  1  request accepted and response not yet given.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  32  bus-word-aligned address (low log2(BUS_BYTES) bits = 0).
- mem_sel_o  out  BUS_BYTES  lane enables.
- mem_wdata_o  out  8*BUS_BYTES  store lanes.
- mem_ack_i  in  1  beat completes this cycle.
- mem_rdata_i  in  8*BUS_BYTES  read lanes, valid when mem_ack_i=1.

Behaviour:
- Reset (async, any state): FSM=IDLE; every output 0 except req_ready_o=1; beat counter and assembly register cleared; mem_req_o drops immediately.
- States: IDLE, ACCESS, DONE.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, capture all request fields. Size N = 1/2/4 bytes from func3. Error if func3 is not legal for the direction, or (MISALIGN_OK=0 and addr not N-aligned). Error -> DONE; otherwise -> ACCESS.
- ACCESS: stall_o=1; mem_req_o=1 continuously.
  - Beat k covers the bytes of [A, A+N-1] that fall in one aligned bus word, ascending addresses. Beats = number of bus words touched, max 4 (BUS_BYTES=1, LW) or 2 when the access straddles a bus-word boundary.
  - mem_addr_o, mem_sel_o, mem_wdata_o, mem_we_o stay stable until mem_ack_i is sampled high. Next beat's fields appear the following cycle with mem_req_o still high. After the last ack -> DONE.
  - Lane of byte offset o in bus word: BIG_ENDIAN ? BUS_BYTES-1-o : o. mem_sel_o bit index equals lane index.
  - Store byte j (0 = lowest address) = BIG_ENDIAN ? wdata_i[8(N-1-j)+:8] : wdata_i[8j+:8]. Unselected lanes drive 0.
  - Load bytes are written into the assembly register at the same positions on each ack.
- DONE: resp_valid_o=1 for exactly one cycle, stall_o=1, then -> IDLE.
  - wd_o = captured wd.
  - wreg_o=1 only for a non-error load.
  - wdata_o: LB/LH sign-extend from bit 8N-1; LBU/LHU zero-extend; 0 for stores and errors.
  - err_o valid only this cycle.
- Latency: accept at edge 0, zero-wait ack -> resp_valid_o in cycle beats+1; each wait cycle adds 1. Error -> resp_valid_o in cycle 1 with no mem_req_o.
- wd/wdata outputs hold their last value in IDLE; resp_valid_o is the only qualifier.
- req_valid_i is ignored outside IDLE.
- mem_ack_i is ignored outside ACCESS.
- Async reset mid-ACCESS abandons the beat; a partial store may have committed earlier beats (accepted).

Test Plan:
- BUS_BYTES=4, BIG_ENDIAN=1, LB addr 0x103, rdata 0x112233F0, ack same cycle -> mem_addr_o=0x100, sel=0001, resp in cycle 2, wdata_o=0xFFFFFFF0, wreg_o=1.
- BUS_BYTES=1, SW addr 0x200, wdata 0xA1B2C3D4, BIG_ENDIAN=1 -> 4 beats at 0x200..0x203, mem_wdata_o A1,B2,C3,D4, sel=1, resp cycle 5, wreg_o=0.
- BUS_BYTES=4, BIG_ENDIAN=0, LHU addr 0x3 with 2 wait cycles per beat -> beats at 0x0 (sel 1000) and 0x4 (sel 0001); bytes 0x80 then 0x7F give wdata_o=0x00007F80; resp cycle 7.
- MISALIGN_OK=0, LW addr 0x6 -> no mem_req_o, resp cycle 1, err_o=1, wreg_o=0; load func3=011 -> same error.
- Async rst low mid-ACCESS with mem_req_o=1 -> mem_req_o=0 immediately, req_ready_o=1. Next LW after release completes normally.
- Back-to-back: req_valid_i held high with two LBU -> second accepted only in the IDLE cycle after the first resp; stall_o high throughout each access.
